alu_exec_unit: RTL and testbench

- Execute-stage ALU that consumes the 4-bit ALUop produced by the ALU decoder, plus two 32-bit operands, and returns a registered result.
- Uses valid/ready handshakes on both input and output.
- Shifts run iteratively, one bit per cycle, to avoid a barrel shifter.
- All other operations complete in one cycle.
- Sits between the register-read/decode stage and writeback.
- Used by the multi-cycle datapath and by the branch-compare path (zero flag).

---
 rtl/alu_exec_unit_pkg.sv | 22 ++
 rtl/alu_exec_unit_comb.sv | 36 +++
 rtl/alu_exec_unit.sv | 101 ++++++++++
 tb/tb_alu_exec_unit.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_unit_pkg.sv
// Shared ALUop encodings used by the decoder and the execute-stage ALU.
// Codes 12..15 are undefined and flagged as illegal by the ALU.
package alu_exec_unit_pkg;

   localparam logic [3:0] ALU_ADDU = 4'd0;
   localparam logic [3:0] ALU_SUBU = 4'd1;
   localparam logic [3:0] ALU_SLT  = 4'd2;
   localparam logic [3:0] ALU_SLTU = 4'd3;
   localparam logic [3:0] ALU_AND  = 4'd4;
   localparam logic [3:0] ALU_OR   = 4'd5;
   localparam logic [3:0] ALU_XOR  = 4'd6;
   localparam logic [3:0] ALU_NOR  = 4'd7;
   localparam logic [3:0] ALU_LUI  = 4'd8;
   localparam logic [3:0] ALU_SLL  = 4'd9;
   localparam logic [3:0] ALU_SRL  = 4'd10;
   localparam logic [3:0] ALU_SRA  = 4'd11;

   function automatic logic is_shift(input logic [3:0] op);
      return (op == ALU_SLL) | (op == ALU_SRL) | (op == ALU_SRA);
   endfunction

endpackage

// File: rtl/alu_exec_unit_comb.sv
// Single-cycle ALU datapath: arithmetic, compare, logic and LUI.
// Shift encodings are legal here but produce 0; the iterative shifter owns them.
module alu_comb_core
   import alu_exec_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [3:0]       alu_op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] res,
   output logic             illegal
);

   always_comb begin
      res     = '0;
      illegal = 1'b0;
      unique case (1'b1)
         (alu_op == ALU_ADDU): res = a + b;
         (alu_op == ALU_SUBU): res = a - b;
         (alu_op == ALU_SLT):
            res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         (alu_op == ALU_SLTU):
            res = {{(WIDTH-1){1'b0}}, a < b};
         (alu_op == ALU_AND):  res = a & b;
         (alu_op == ALU_OR):   res = a | b;
         (alu_op == ALU_XOR):  res = a ^ b;
         (alu_op == ALU_NOR):  res = ~(a | b);
         (alu_op == ALU_LUI):
            res = WIDTH'({b[15:0], 16'h0000});
         is_shift(alu_op):     res = '0;
         default:              illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes, registered result
// and a one-bit-per-cycle shifter in place of a barrel shifter.
module alu_exec_unit
   import alu_exec_unit_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       alu_op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             illegal
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]         state;
   logic [WIDTH-1:0]   sreg;
   logic [WIDTH-1:0]   sreg_nxt;
   logic [SHAMT_W-1:0] cnt;
   logic [SHAMT_W-1:0] n;
   logic [3:0]         sop;
   logic [WIDTH-1:0]   core_res;
   logic               core_ill;
   logic               acc;

   alu_comb_core #(.WIDTH(WIDTH)) u_core (
      .alu_op  (alu_op),
      .a       (a),
      .b       (b),
      .res     (core_res),
      .illegal (core_ill)
   );

   assign n         = a[SHAMT_W-1:0];
   assign out_valid = (state == DONE);
   assign in_ready  = rst_n & ((state == IDLE) |
                               ((state == DONE) & out_ready));
   assign acc       = in_valid & in_ready;

   always_comb begin
      sreg_nxt = {sreg[WIDTH-1], sreg[WIDTH-1:1]};
      unique case (1'b1)
         (sop == ALU_SLL): sreg_nxt = {sreg[WIDTH-2:0], 1'b0};
         (sop == ALU_SRL): sreg_nxt = {1'b0, sreg[WIDTH-1:1]};
         default:          sreg_nxt = {sreg[WIDTH-1], sreg[WIDTH-1:1]};
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         result  <= '0;
         zero    <= 1'b0;
         illegal <= 1'b0;
         sreg    <= '0;
         cnt     <= '0;
         sop     <= ALU_ADDU;
      end else if (acc) begin
         if (is_shift(alu_op) && (n != '0)) begin
            sreg  <= b;
            cnt   <= n;
            sop   <= alu_op;
            state <= SHIFT;
         end else begin
            state   <= DONE;
            illegal <= core_ill;
            if (is_shift(alu_op)) begin
               result <= b;
               zero   <= (b == '0);
            end else begin
               result <= core_res;
               zero   <= (core_res == '0);
            end
         end
      end else if (state == SHIFT) begin
         sreg <= sreg_nxt;
         cnt  <= cnt - 1'b1;
         // last step lands straight in the result register
         if (cnt == SHAMT_W'(1)) begin
            result  <= sreg_nxt;
            zero    <= (sreg_nxt == '0);
            illegal <= 1'b0;
            state   <= DONE;
         end
      end else if ((state == DONE) && out_ready) begin
         state <= IDLE;
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized bench for alu_exec_unit against an arithmetic reference
// model and a queue of expected results with due cycles.
module tb_alu_exec_unit;
   import alu_exec_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  alu_op = 4'd0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result;
   logic        zero;
   logic        illegal;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   bit rnd_or = 1'b0;

   typedef struct {
      logic [31:0] r;
      logic        il;
      int          due;
   } exp_t;
   exp_t q[$];

   alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_op    (alu_op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)",
                    nm, got, exp, $time);
   endtask

   function automatic logic [32:0] ref_alu(input logic [3:0] op,
                                           input logic [31:0] x,
                                           input logic [31:0] y);
      logic [31:0] r;
      logic        il;
      r  = '0;
      il = 1'b0;
      case (op)
         ALU_ADDU: r = x + y;
         ALU_SUBU: r = x - y;
         ALU_SLT:  r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         ALU_SLTU: r = (x < y) ? 32'd1 : 32'd0;
         ALU_AND:  r = x & y;
         ALU_OR:   r = x | y;
         ALU_XOR:  r = x ^ y;
         ALU_NOR:  r = ~(x | y);
         ALU_LUI:  r = y * 32'h10000;
         ALU_SLL:  r = y << x[4:0];
         ALU_SRL:  r = y >> x[4:0];
         ALU_SRA:  r = 32'($signed(y) >>> x[4:0]);
         default:  il = 1'b1;
      endcase
      return {il, r};
   endfunction

   function automatic int ref_lat(input logic [3:0] op,
                                  input logic [31:0] x);
      if (is_shift(op) && x[4:0] != 5'd0) return int'(x[4:0]) + 1;
      return 1;
   endfunction

   // scoreboard update: pop consumed result, then push newly accepted op
   always @(posedge clk) begin
      cyc++;
      if (!rst_n) q.delete();
      else begin
         if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
         if (in_valid && in_ready) begin
            exp_t e;
            logic [32:0] m;
            m     = ref_alu(alu_op, a, b);
            e.r   = m[31:0];
            e.il  = m[32];
            e.due = cyc + ref_lat(alu_op, a) - 1;
            q.push_back(e);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_valid", out_valid, 0);
         chk("rst_result", result, 0);
         chk("rst_zero", zero, 0);
         chk("rst_illegal", illegal, 0);
         chk("rst_in_ready", in_ready, 0);
      end else if (q.size() == 0) begin
         chk("idle_valid", out_valid, 0);
         chk("idle_in_ready", in_ready, 1);
      end else if (cyc < q[0].due) begin
         chk("busy_valid", out_valid, 0);
         chk("busy_in_ready", in_ready, 0);
      end else begin
         chk("out_valid", out_valid, 1);
         chk("result", result, q[0].r);
         chk("zero", zero, q[0].r == 32'd0);
         chk("illegal", illegal, q[0].il);
         chk("done_in_ready", in_ready, out_ready);
      end
   end

   always @(posedge clk) begin
      if (rnd_or) begin
         #1;
         out_ready = ($urandom_range(3) != 0);
      end
   end

   task automatic send(input logic [3:0] op, input logic [31:0] x,
                       input logic [31:0] y, output int w);
      bit hs;
      alu_op   = op;
      a        = x;
      b        = y;
      in_valid = 1'b1;
      w        = 0;
      forever begin
         @(negedge clk);
         hs = in_ready;
         @(posedge clk);
         #1;
         w++;
         if (hs) break;
         if (w > 200) begin
            chk("handshake_timeout", 0, 1);
            break;
         end
      end
   endtask

   task automatic idle();
      in_valid = 1'b0;
      alu_op   = 4'($urandom);
      a        = $urandom;
      b        = $urandom;
   endtask

   task automatic lit(input string nm, input logic [3:0] op,
                      input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] er, input logic ei,
                      input int el);
      int w;
      int lat;
      out_ready = 1'b1;
      send(op, x, y, w);
      idle();
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 40);
      chk({nm, "_lat"}, lat, el);
      chk({nm, "_res"}, result, er);
      chk({nm, "_zero"}, zero, er == 32'd0);
      chk({nm, "_ill"}, illegal, ei);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int w;
      logic [31:0] held;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      lit("addu_wrap", ALU_ADDU, 32'hFFFF_FFFF, 32'h2, 32'h1, 0, 1);
      lit("slt", ALU_SLT, 32'hFFFF_FFFF, 32'h1, 32'h1, 0, 1);
      lit("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0, 0, 1);
      lit("subu_zero", ALU_SUBU, 32'h1234, 32'h1234, 32'h0, 0, 1);
      lit("sra4", ALU_SRA, 32'h4, 32'h8000_0000, 32'hF800_0000, 0, 5);
      lit("sll0", ALU_SLL, 32'h0, 32'hCAFE_0001, 32'hCAFE_0001, 0, 1);
      lit("srl31", ALU_SRL, 32'h1F, 32'h8000_0000, 32'h1, 0, 32);

      // back-to-back single-cycle ops
      out_ready = 1'b1;
      send(ALU_ADDU, 32'h10, 32'h20, w);
      send(ALU_OR, 32'hF0, 32'h0F, w);
      chk("b2b_or_hs", w, 1);
      send(ALU_LUI, 32'h0, 32'h0000_1234, w);
      chk("b2b_lui_hs", w, 1);
      idle();
      @(negedge clk);
      chk("b2b_lui_valid", out_valid, 1);
      chk("b2b_lui_res", result, 32'h1234_0000);
      @(posedge clk);
      #1;

      // backpressure holds the result, then release with a new op
      out_ready = 1'b0;
      send(ALU_XOR, 32'h5, 32'h6, w);
      idle();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_valid", out_valid, 1);
         chk("bp_res", result, 32'h3);
         chk("bp_in_ready", in_ready, 0);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      send(ALU_NOR, 32'h0, 32'h0, w);
      chk("bp_release_hs", w, 1);
      idle();
      @(negedge clk);
      chk("bp_nor_res", result, 32'hFFFF_FFFF);
      @(posedge clk);
      #1;

      lit("undef", 4'b1111, 32'h55, 32'hAA, 32'h0, 1, 1);
      lit("pre_rst", ALU_ADDU, 32'h7, 32'h8, 32'hF, 0, 1);

      // reset in the middle of a long shift
      send(ALU_SLL, 32'd20, 32'h1, w);
      idle();
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", out_valid, 0);
      chk("midrst_res", result, 0);
      chk("midrst_in_ready", in_ready, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      lit("post_rst", ALU_ADDU, 32'h3, 32'h4, 32'h7, 0, 1);

      // randomized traffic with random backpressure
      rnd_or = 1'b1;
      for (int i = 0; i < 400; i++) begin
         logic [3:0]  op;
         logic [31:0] x;
         logic [31:0] y;
         op = ($urandom_range(7) == 0) ? 4'(12 + $urandom_range(3))
                                        : 4'($urandom_range(11));
         x  = $urandom;
         y  = $urandom;
         if ($urandom_range(5) == 0) y = x;
         if ($urandom_range(7) == 0) y = 32'h0;
         if (is_shift(op) && $urandom_range(1) == 0)
            x = 32'($urandom_range(3));
         send(op, x, y, w);
         idle();
         repeat ($urandom_range(2)) begin
            @(posedge clk);
            #1;
         end
      end
      rnd_or = 1'b0;
      #2 out_ready = 1'b1;
      for (int i = 0; i < 100 && q.size() > 0; i++) begin
         @(posedge clk);
         #1 out_ready = 1'b1;
      end
      chk("drain", q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
